// File: rtl/col_dec_pkg.sv
// Shared FSM state encoding, address-width bounds and the 2-bit segment decoder
// used by the column burst decoder.
package col_dec_pkg;

  localparam int MIN_ADDR_WIDTH = 2;
  localparam int MAX_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } col_state_e;

  function automatic logic [3:0] seg_decode(input logic [1:0] seg);
    return 4'b0001 << seg;
  endfunction

endpackage

// File: rtl/col_predecoder.sv
// Splits an address into 2-bit segments and decodes each into a 4-bit one-hot
// group; all groups are forced to zero when en is low.
module col_predecoder
  import col_dec_pkg::*;
#(
  parameter int SEGS = 2
) (
  input  logic [2*SEGS-1:0] addr,
  input  logic              en,
  output logic [4*SEGS-1:0] groups
);

  always_comb begin
    groups = '0;
    for (int s = 0; s < SEGS; s++) begin
      groups[s*4 +: 4] = en ? seg_decode(addr[s*2 +: 2]) : 4'b0000;
    end
  end

endmodule

// File: rtl/col_burst_decoder.sv
// Burst column decoder: walks a one-hot column select through a burst of
// consecutive columns. Optional checker output enabled by COL_DEC_ONEHOT_CHK_EN.
module col_burst_decoder
  import col_dec_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_COLS   = 2**ADDR_WIDTH,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  wrap_en,
  input  logic                  advance,
  input  logic                  abort,
  output logic [NUM_COLS-1:0]   col_select,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  truncated
`ifdef COL_DEC_ONEHOT_CHK_EN
  ,
  output logic                  onehot_err
`endif
);

  // Handshake: advance is a single-cycle strobe meaning "the beat now on
  // col_select was consumed"; it only has effect in ACTIVE, abort overrides it.

  localparam int SEGS = ADDR_WIDTH / 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(NUM_COLS - 1);

  col_state_e state, state_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [LEN_WIDTH-1:0]  cnt, cnt_n;
  logic                  wrap_q, wrap_n;
  logic                  trunc_n;
  logic [4*SEGS-1:0]     groups;
  logic [NUM_COLS-1:0]   onehot_n;

  always_comb begin
    state_n = state;
    addr_n  = cur_addr;
    cnt_n   = cnt;
    wrap_n  = wrap_q;
    trunc_n = truncated;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_ACTIVE;
          addr_n  = start_addr;
          cnt_n   = burst_len;
          wrap_n  = wrap_en;
          trunc_n = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (advance) begin
          if (cnt == '0) begin
            state_n = ST_DONE;
          end else if (cur_addr == LAST_COL && !wrap_q) begin
            // Non-wrapping burst ran off the top column with beats left over.
            state_n = ST_DONE;
            trunc_n = 1'b1;
          end else begin
            addr_n = (cur_addr == LAST_COL) ? '0 : cur_addr + 1'b1;
            cnt_n  = cnt - 1'b1;
          end
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Decode the next address so the registered select lines up with cur_addr.
  col_predecoder #(.SEGS(SEGS)) u_predec (
    .addr   (addr_n),
    .en     (state_n == ST_ACTIVE),
    .groups (groups)
  );

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [SEGS-1:0] seg_hit;
    for (genvar s = 0; s < SEGS; s++) begin : g_seg
      assign seg_hit[s] = groups[s*4 + ((c >> (2*s)) % 4)];
    end
    assign onehot_n[c] = &seg_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_addr   <= '0;
      cnt        <= '0;
      wrap_q     <= 1'b0;
      truncated  <= 1'b0;
      col_select <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cur_addr   <= addr_n;
      cnt        <= cnt_n;
      wrap_q     <= wrap_n;
      truncated  <= trunc_n;
      col_select <= onehot_n;
      busy       <= (state_n != ST_IDLE);
      done       <= (state_n == ST_DONE);
    end
  end

`ifdef COL_DEC_ONEHOT_CHK_EN
  logic multi_hot;
  assign multi_hot = |(col_select & (col_select - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_err <= 1'b0;
    end else if (multi_hot || (state == ST_ACTIVE && col_select == '0)) begin
      onehot_err <= 1'b1;
    end
  end
`else
  // Default build carries no select-integrity checker.
`endif

endmodule

// File: tb/tb_col_burst_decoder.sv
// Bench for col_burst_decoder (ADDR_WIDTH=4): directed vector table, hand-written
// reset sequence, and random traffic checked against a burst-list model.
module tb_col_burst_decoder;

  localparam int AW = 4;
  localparam int NC = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] burst_len = '0;
  logic          wrap_en = 1'b0;
  logic          advance = 1'b0;
  logic          abort = 1'b0;
  logic [NC-1:0] col_select;
  logic [AW-1:0] cur_addr;
  logic          busy;
  logic          done;
  logic          truncated;
`ifdef COL_DEC_ONEHOT_CHK_EN
  logic          onehot_err;
`endif

  col_burst_decoder #(.ADDR_WIDTH(AW), .NUM_COLS(NC), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .wrap_en    (wrap_en),
    .advance    (advance),
    .abort      (abort),
    .col_select (col_select),
    .cur_addr   (cur_addr),
    .busy       (busy),
    .done       (done),
    .truncated  (truncated)
`ifdef COL_DEC_ONEHOT_CHK_EN
    ,
    .onehot_err (onehot_err)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A burst is the list of columns it will visit; progress is an index into it.
  int m_phase = 0;   // 0 idle, 1 active, 2 done
  int m_pos   = 0;
  int m_addr  = 0;
  int m_len   = 0;
  bit m_trunc = 1'b0;
  int beats[$];

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_addr = 0; m_trunc = 1'b0; beats.delete();
  endtask

  task automatic model_edge();
    case (m_phase)
      0: if (start) begin
        beats.delete();
        for (int i = 0; i <= int'(burst_len); i++) begin
          int a;
          a = int'(start_addr) + i;
          if (a >= NC) begin
            if (wrap_en) a = a % NC;
            else break;
          end
          beats.push_back(a);
        end
        m_len = int'(burst_len) + 1;
        m_pos = 0; m_addr = int'(start_addr); m_trunc = 1'b0; m_phase = 1;
      end
      1: if (abort) m_phase = 0;
         else if (advance) begin
           if (m_pos == beats.size() - 1) begin
             m_phase = 2;
             if (beats.size() < m_len) m_trunc = 1'b1;
           end else begin
             m_pos++;
             m_addr = beats[m_pos];
           end
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [15:0] e_cs;
    e_cs = (m_phase == 1) ? (16'h0001 << beats[m_pos]) : 16'h0000;
    chk({tag, ".cur_addr"},   32'(cur_addr),   32'(m_addr));
    chk({tag, ".col_select"}, 32'(col_select), 32'(e_cs));
    chk({tag, ".busy"},       32'(busy),       32'(m_phase != 0));
    chk({tag, ".done"},       32'(done),       32'(m_phase == 2));
    chk({tag, ".truncated"},  32'(truncated),  32'(m_trunc));
    if (busy && !done) chk({tag, ".onehot"}, 32'($countones(col_select)), 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic [3:0] sa, input logic [3:0] bl,
                       input logic wr, input logic adv, input logic ab);
    start = st; start_addr = sa; burst_len = bl; wrap_en = wr; advance = adv; abort = ab;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply(input logic st, input logic [3:0] sa, input logic [3:0] bl,
                       input logic wr, input logic adv, input logic ab);
    @(negedge clk);
    drive(st, sa, bl, wr, adv, ab);
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic st; logic [3:0] sa; logic [3:0] bl; logic wr; logic adv; logic ab;
    logic [3:0] e_addr; logic [15:0] e_cs; logic e_busy; logic e_done; logic e_trunc;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic st, input logic [3:0] sa, input logic [3:0] bl,
                     input logic wr, input logic adv, input logic ab,
                     input logic [3:0] ea, input logic [15:0] ec,
                     input logic eb, input logic ed, input logic et);
    vec_t v;
    v.st = st; v.sa = sa; v.bl = bl; v.wr = wr; v.adv = adv; v.ab = ab;
    v.e_addr = ea; v.e_cs = ec; v.e_busy = eb; v.e_done = ed; v.e_trunc = et;
    vecs.push_back(v);
  endtask

  initial begin
    // burst 5..7 with wrap; a start mid-burst and one in DONE are ignored
    add(1, 5, 2, 1, 1, 0,   5, 16'h0020, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   6, 16'h0040, 1, 0, 0);
    add(1, 9, 0, 0, 1, 0,   7, 16'h0080, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   7, 16'h0000, 1, 1, 0);
    add(1, 9, 0, 0, 0, 0,   7, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   7, 16'h0000, 0, 0, 0);
    // wrapping burst 14,15,0,1
    add(1, 14, 3, 1, 1, 0, 14, 16'h4000, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,  15, 16'h8000, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   0, 16'h0001, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   1, 16'h0002, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   1, 16'h0000, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,   1, 16'h0000, 0, 0, 0);
    // non-wrapping burst truncated at the top column
    add(1, 14, 3, 0, 0, 0, 14, 16'h4000, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,  15, 16'h8000, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,  15, 16'h0000, 1, 1, 1);
    add(0, 0, 0, 0, 1, 0,  15, 16'h0000, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  15, 16'h0000, 0, 0, 1);
    // abort wins over advance on beat 2; truncated cleared by the start
    add(1, 3, 5, 1, 0, 0,   3, 16'h0008, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   4, 16'h0010, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1,   4, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 16'h0000, 0, 0, 0);
    // advance gaps hold the address; abort during DONE
    add(1, 0, 1, 0, 0, 0,   0, 16'h0001, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 16'h0001, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 16'h0001, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   1, 16'h0002, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   1, 16'h0000, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 16'h0000, 0, 0, 0);
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    #12;
    chk("reset.col_select", 32'(col_select), 32'h0);
    chk("reset.cur_addr",   32'(cur_addr),   32'h0);
    chk("reset.busy",       32'(busy),       32'h0);
    chk("reset.done",       32'(done),       32'h0);
    chk("reset.truncated",  32'(truncated),  32'h0);

    // Row 0 starts on the very first rising edge after reset release.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      drive(vecs[i].st, vecs[i].sa, vecs[i].bl, vecs[i].wr, vecs[i].adv, vecs[i].ab);
      tick();
      chk($sformatf("vec%0d.cur_addr", i),   32'(cur_addr),   32'(vecs[i].e_addr));
      chk($sformatf("vec%0d.col_select", i), 32'(col_select), 32'(vecs[i].e_cs));
      chk($sformatf("vec%0d.busy", i),       32'(busy),       32'(vecs[i].e_busy));
      chk($sformatf("vec%0d.done", i),       32'(done),       32'(vecs[i].e_done));
      chk($sformatf("vec%0d.truncated", i),  32'(truncated),  32'(vecs[i].e_trunc));
    end

    // Asynchronous reset in the middle of a burst, between clock edges.
    apply(1, 2, 5, 1, 0, 0);
    check_model("rst_pre0");
    apply(0, 0, 0, 0, 1, 0);
    check_model("rst_pre1");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.col_select", 32'(col_select), 32'h0);
    chk("async_rst.busy",       32'(busy),       32'h0);
    chk("async_rst.cur_addr",   32'(cur_addr),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 10, 1, 0, 0, 0);
    tick();
    check_model("rst_post0");
    apply(0, 0, 0, 0, 1, 0);
    check_model("rst_post1");
    apply(0, 0, 0, 0, 1, 0);
    check_model("rst_post2");
    apply(0, 0, 0, 0, 0, 0);
    check_model("rst_post3");

    // Random traffic: frequent start attempts, advance gaps, rare aborts.
    for (int n = 0; n < 600; n++) begin
      logic st, wr, adv, ab;
      logic [3:0] sa, bl;
      st  = ($urandom_range(0, 2) == 0);
      sa  = 4'($urandom_range(0, 15));
      bl  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      wr  = 1'($urandom_range(0, 1));
      adv = ($urandom_range(0, 2) != 0);
      ab  = ($urandom_range(0, 29) == 0);
      apply(st, sa, bl, wr, adv, ab);
      check_model($sformatf("rnd%0d", n));
    end

`ifdef COL_DEC_ONEHOT_CHK_EN
    chk("onehot_err", 32'(onehot_err), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
